// File: rtl/stereo_pkg.sv
// Shared types and geometry for the stereo column feeder.
// Pixel/column types, frame dimensions and line-store slot arithmetic.
package stereo_pkg;

  localparam int KERNEL_WIDTH = 3;
  localparam int H_ACTIVE     = 320;
  localparam int V_ACTIVE     = 240;

  localparam int NUM_SLOTS = KERNEL_WIDTH - 1;
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int ROW_W     = $clog2(KERNEL_WIDTH);
  localparam int ADDR_W    = $clog2(H_ACTIVE);

  typedef logic [7:0]                 pixel_t;
  typedef pixel_t [KERNEL_WIDTH-1:0]  column_t;
  typedef logic [SLOT_W-1:0]          slot_t;

  // Ring-buffer index arithmetic over the line-store slots.
  function automatic slot_t slot_add(slot_t base, int offset);
    int sum;
    sum = int'(base) + offset;
    return slot_t'(sum % NUM_SLOTS);
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: single write port, read-first registered read port.
module line_ram
  import stereo_pkg::*;
(
  input  logic              clk_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [7:0]        wr_data_in,
  input  logic              rd_en_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [7:0]        rd_data_out
);

  pixel_t mem_q [H_ACTIVE];
  pixel_t rd_data_q;

  // Read and write share an edge; the read sees the pre-write contents.
  always_ff @(posedge clk_in) begin
    if (rd_en_in) rd_data_q <= mem_q[rd_addr_in];
    if (wr_en_in) mem_q[wr_addr_in] <= wr_data_in;
  end

  assign rd_data_out = rd_data_q;

endmodule

// File: rtl/stereo_column_feeder.sv
// Buffers KERNEL_WIDTH-1 lines per camera and emits one vertical column per
// accepted pixel pair, paced by the SAD engine's busy handshake.
module stereo_column_feeder
  import stereo_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  input  logic [7:0]  left_pixel_in,
  input  logic [7:0]  right_pixel_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        sad_busy_in,
  output logic        data_valid_out,
  output column_t     left_data_out,
  output column_t     right_data_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);

  logic adv, accept, in_range, frame_start, store;
  slot_t wr_slot, wr_line_q, wr_line_d;
  logic [ROW_W-1:0] row_eff, row_count_q, row_count_d;
  logic frame_seen_q, frame_seen_d;

  logic        s1_emit_q, s1_emit_d;
  pixel_t      s1_left_q, s1_left_d, s1_right_q, s1_right_d;
  logic [10:0] s1_hcount_q, s1_hcount_d;
  logic [9:0]  s1_vcount_q, s1_vcount_d;
  slot_t       s1_slot_q, s1_slot_d;

  logic        data_valid_q, data_valid_d;
  column_t     left_data_q, left_data_d, right_data_q, right_data_d;
  column_t     left_col, right_col;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;

  pixel_t left_rd  [NUM_SLOTS];
  pixel_t right_rd [NUM_SLOTS];

  always_comb begin
    adv         = !(data_valid_q && sad_busy_in);
    accept      = pixel_valid_in && adv;
    in_range    = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
    frame_start = (hcount_in == '0) && (vcount_in == '0);
    store       = accept && in_range;
    wr_slot     = frame_start ? '0 : wr_line_q;
    row_eff     = frame_start ? '0 : row_count_q;
    wr_line_d    = wr_line_q;
    row_count_d  = row_count_q;
    frame_seen_d = frame_seen_q;
    if (store) begin
      if (frame_start) begin
        wr_line_d    = '0;
        row_count_d  = '0;
        frame_seen_d = 1'b1;
      end else if (hcount_in == 11'(H_ACTIVE - 1)) begin
        wr_line_d   = slot_add(wr_line_q, 1);
        row_count_d = (row_count_q == ROW_W'(NUM_SLOTS)) ? row_count_q
                                                         : row_count_q + ROW_W'(1);
      end
    end
  end

  // Columns are only produced once a frame start has been seen since reset.
  always_comb begin
    s1_emit_d   = s1_emit_q;
    s1_left_d   = s1_left_q;
    s1_right_d  = s1_right_q;
    s1_hcount_d = s1_hcount_q;
    s1_vcount_d = s1_vcount_q;
    s1_slot_d   = s1_slot_q;
    if (adv) begin
      s1_emit_d   = store && frame_seen_q && (row_eff == ROW_W'(NUM_SLOTS));
      s1_left_d   = left_pixel_in;
      s1_right_d  = right_pixel_in;
      s1_hcount_d = hcount_in;
      s1_vcount_d = vcount_in;
      s1_slot_d   = wr_slot;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic wr_en;
    assign wr_en = store && (wr_slot == slot_t'(g));

    line_ram u_left (
      .clk_in     (clk_in),
      .wr_en_in   (wr_en),
      .wr_addr_in (hcount_in[ADDR_W-1:0]),
      .wr_data_in (left_pixel_in),
      .rd_en_in   (adv),
      .rd_addr_in (hcount_in[ADDR_W-1:0]),
      .rd_data_out(left_rd[g])
    );

    line_ram u_right (
      .clk_in     (clk_in),
      .wr_en_in   (wr_en),
      .wr_addr_in (hcount_in[ADDR_W-1:0]),
      .wr_data_in (right_pixel_in),
      .rd_en_in   (adv),
      .rd_addr_in (hcount_in[ADDR_W-1:0]),
      .rd_data_out(right_rd[g])
    );
  end

  // The slot that was being written holds the oldest row, so it maps to the top.
  always_comb begin
    left_col  = '0;
    right_col = '0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      left_col[j]  = left_rd[slot_add(s1_slot_q, j)];
      right_col[j] = right_rd[slot_add(s1_slot_q, j)];
    end
    left_col[KERNEL_WIDTH-1]  = s1_left_q;
    right_col[KERNEL_WIDTH-1] = s1_right_q;
  end

  always_comb begin
    data_valid_d = data_valid_q;
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    if (adv) begin
      data_valid_d = s1_emit_q;
      if (s1_emit_q) begin
        left_data_d  = left_col;
        right_data_d = right_col;
        hcount_d     = s1_hcount_q;
        vcount_d     = s1_vcount_q;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_line_q    <= '0;
      row_count_q  <= '0;
      frame_seen_q <= 1'b0;
      s1_emit_q    <= 1'b0;
      s1_left_q    <= '0;
      s1_right_q   <= '0;
      s1_hcount_q  <= '0;
      s1_vcount_q  <= '0;
      s1_slot_q    <= '0;
      data_valid_q <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      hcount_q     <= '0;
      vcount_q     <= '0;
    end else begin
      wr_line_q    <= wr_line_d;
      row_count_q  <= row_count_d;
      frame_seen_q <= frame_seen_d;
      s1_emit_q    <= s1_emit_d;
      s1_left_q    <= s1_left_d;
      s1_right_q   <= s1_right_d;
      s1_hcount_q  <= s1_hcount_d;
      s1_vcount_q  <= s1_vcount_d;
      s1_slot_q    <= s1_slot_d;
      data_valid_q <= data_valid_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
    end
  end

  assign pixel_ready_out = adv;
  assign data_valid_out  = data_valid_q;
  assign left_data_out   = left_data_q;
  assign right_data_out  = right_data_q;
  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;

endmodule

// File: tb/tb_stereo_column_feeder.sv
// Testbench for stereo_column_feeder: directed frame sequence with random pixels
// and busy patterns, checked against a per-column pixel history model.
module tb_stereo_column_feeder;
  import stereo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        pixel_valid_in;
  logic        pixel_ready_out;
  logic [7:0]  left_pixel_in, right_pixel_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        sad_busy_in;
  logic        data_valid_out;
  column_t     left_data_out, right_data_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  stereo_column_feeder dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_ready_out(pixel_ready_out),
    .left_pixel_in  (left_pixel_in),
    .right_pixel_in (right_pixel_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .sad_busy_in    (sad_busy_in),
    .data_valid_out (data_valid_out),
    .left_data_out  (left_data_out),
    .right_data_out (right_data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    column_t     l;
    column_t     r;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;

  exp_t   expq[$];
  pixel_t histL1 [H_ACTIVE];
  pixel_t histL2 [H_ACTIVE];
  pixel_t histR1 [H_ACTIVE];
  pixel_t histR2 [H_ACTIVE];
  bit     synced;
  int     rowsDone;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int busyMode = 0;
  int holdCnt = 0;
  bit gapMode = 0;
  bit lastAcc = 0;
  bit prevHold = 0;
  column_t     prevL, prevR;
  logic [10:0] prevH;
  logic [9:0]  prevV;
  bit phaseA = 0;
  int latAccCycle = -100;
  int row2Cnt = 0;
  int validSeen = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: each column remembers its last two stored pixels.
  function automatic void modelAccept(input int h, input int v, input pixel_t l, input pixel_t r);
    exp_t e;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return;
    if (h == 0 && v == 0) begin
      synced   = 1'b1;
      rowsDone = 0;
    end
    if (synced && rowsDone >= KERNEL_WIDTH - 1) begin
      e.l = {l, histL1[h], histL2[h]};
      e.r = {r, histR1[h], histR2[h]};
      e.h = 11'(h);
      e.v = 10'(v);
      expq.push_back(e);
    end
    histL2[h] = histL1[h];
    histL1[h] = l;
    histR2[h] = histR1[h];
    histR1[h] = r;
    if (h == H_ACTIVE - 1) rowsDone++;
  endfunction

  task automatic tick();
    bit acc, cons;
    exp_t e;
    @(negedge clk);
    acc  = pixel_valid_in && pixel_ready_out;
    cons = data_valid_out && !sad_busy_in;
    checkOutput("ready", pixel_ready_out, !(data_valid_out && sad_busy_in));
    if (data_valid_out) validSeen++;
    if (prevHold) begin
      checkOutput("hold_valid", data_valid_out, 1'b1);
      checkOutput("hold_left", left_data_out, prevL);
      checkOutput("hold_right", right_data_out, prevR);
      checkOutput("hold_hcount", hcount_out, prevH);
      checkOutput("hold_vcount", vcount_out, prevV);
    end
    if (cons) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_valid", data_valid_out, 1'b0);
      end else begin
        e = expq.pop_front();
        checkOutput("left_col", left_data_out, e.l);
        checkOutput("right_col", right_data_out, e.r);
        checkOutput("hcount", hcount_out, e.h);
        checkOutput("vcount", vcount_out, e.v);
        if (phaseA && e.v == 2) row2Cnt++;
        if (phaseA && e.v == 2 && e.h == 5) begin
          checkOutput("ramp_left", left_data_out, 24'h25_15_05);
          checkOutput("ramp_right", right_data_out, 24'h26_16_06);
          checkOutput("latency", 64'(cycle - latAccCycle), 64'd2);
        end
      end
    end
    if (acc) begin
      modelAccept(int'(hcount_in), int'(vcount_in), left_pixel_in, right_pixel_in);
      if (phaseA && hcount_in == 5 && vcount_in == 2) latAccCycle = cycle;
    end
    lastAcc  = acc;
    prevHold = data_valid_out && sad_busy_in;
    prevL = left_data_out;
    prevR = right_data_out;
    prevH = hcount_out;
    prevV = vcount_out;
    cycle++;
    @(posedge clk);
    #1;
    case (busyMode)
      1: begin
        if (cons) holdCnt = 11;
        else if (holdCnt > 0) holdCnt--;
        sad_busy_in = (holdCnt > 0);
      end
      2: sad_busy_in = ($urandom_range(0, 3) == 0);
      default: sad_busy_in = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input int h, input int v, input pixel_t l, input pixel_t r);
    int n;
    if (gapMode && $urandom_range(0, 3) == 0) begin
      pixel_valid_in = 1'b0;
      tick();
    end
    pixel_valid_in = 1'b1;
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    left_pixel_in  = l;
    right_pixel_in = r;
    n = 0;
    do begin
      tick();
      n++;
    end while (!lastAcc && n < 200);
    if (!lastAcc) checkOutput("accept_timeout", 64'(n), 64'd0);
    pixel_valid_in = 1'b0;
  endtask

  task automatic sendRow(input int v, input bit ramp, input int firstCol, input int lastCol);
    pixel_t l;
    for (int h = firstCol; h <= lastCol; h++) begin
      if (ramp) l = pixel_t'((16 * v + h) & 8'hFF);
      else      l = pixel_t'($urandom_range(0, 255));
      applyStimulus(h, v, l, ramp ? pixel_t'(l + 8'd1) : pixel_t'($urandom_range(0, 255)));
    end
  endtask

  task automatic idle(input int n);
    pixel_valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    pixel_valid_in = 1'b0;
    while (expq.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    checkOutput("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    pixel_valid_in = 1'b0;
    left_pixel_in = '0;
    right_pixel_in = '0;
    hcount_in = '0;
    vcount_in = '0;
    sad_busy_in = 1'b0;
    synced = 1'b0;
    rowsDone = 0;
    #12;
    checkOutput("reset_valid", data_valid_out, 1'b0);
    checkOutput("reset_left", left_data_out, '0);
    checkOutput("reset_right", right_data_out, '0);
    checkOutput("reset_hcount", hcount_out, '0);
    checkOutput("reset_vcount", vcount_out, '0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;

    $display("[TB] ramp frame warm-up rows");
    phaseA = 1'b1;
    sendRow(0, 1'b1, 0, H_ACTIVE - 1);
    sendRow(1, 1'b1, 0, H_ACTIVE - 1);
    idle(3);
    checkOutput("warmup_no_valid", 64'(validSeen), 64'd0);

    sendRow(2, 1'b1, 0, H_ACTIVE - 1);
    idle(4);
    checkOutput("row2_columns", 64'(row2Cnt), 64'(H_ACTIVE));

    $display("[TB] out-of-range pairs");
    validSeen = 0;
    for (int h = H_ACTIVE; h <= H_ACTIVE + 10; h++)
      applyStimulus(h, 2, pixel_t'($urandom_range(0, 255)), pixel_t'($urandom_range(0, 255)));
    applyStimulus(5, V_ACTIVE, 8'hAA, 8'h55);
    applyStimulus(7, V_ACTIVE + 1, 8'hAA, 8'h55);
    idle(4);
    checkOutput("oor_no_valid", 64'(validSeen), 64'd0);

    $display("[TB] backpressure row");
    busyMode = 1;
    sendRow(3, 1'b1, 0, H_ACTIVE - 1);
    drain();
    busyMode = 0;
    holdCnt = 0;
    idle(2);
    phaseA = 1'b0;

    $display("[TB] random rows and frame wrap");
    busyMode = 2;
    gapMode = 1'b1;
    sendRow(V_ACTIVE - 2, 1'b0, 0, H_ACTIVE - 1);
    sendRow(V_ACTIVE - 1, 1'b0, 0, H_ACTIVE - 1);
    for (int v = 0; v < 5; v++) sendRow(v, 1'b0, 0, H_ACTIVE - 1);

    $display("[TB] reset mid-row");
    busyMode = 0;
    gapMode = 1'b0;
    drain();
    idle(1);
    sendRow(5, 1'b0, 0, 100);
    pixel_valid_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("midreset_valid", data_valid_out, 1'b0);
    checkOutput("midreset_left", left_data_out, '0);
    checkOutput("midreset_hcount", hcount_out, '0);
    expq.delete();
    synced = 1'b0;
    rowsDone = 0;
    prevHold = 1'b0;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    validSeen = 0;
    busyMode = 2;
    gapMode = 1'b1;
    sendRow(5, 1'b0, 101, H_ACTIVE - 1);
    sendRow(6, 1'b0, 0, H_ACTIVE - 1);
    sendRow(7, 1'b0, 0, H_ACTIVE - 1);
    idle(4);
    checkOutput("postreset_no_valid", 64'(validSeen), 64'd0);

    sendRow(0, 1'b0, 0, H_ACTIVE - 1);
    sendRow(1, 1'b0, 0, H_ACTIVE - 1);
    sendRow(2, 1'b0, 0, 39);
    drain();
    idle(6);
    checkOutput("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
